interval_timer_ctrl: RTL and testbench

INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

---
 rtl/interval_timer_ctrl_if.sv | 31 +++
 rtl/interval_timer_ctrl.sv | 110 +++++++++++
 tb/tb_interval_timer_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/interval_timer_ctrl_if.sv
// rtl/interval_timer_ctrl_if.sv - control/status bundle between an interval timer and its environment
// master : environment side (drives commands and the external counter value)
// slave  : timer side (drives counter control and status)
interface interval_timer_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 8
);
    logic             clk_enable;
    logic             start;
    logic             stop;
    logic             hold;
    logic             periodic;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count_q;
    logic             cnt_enable;
    logic             cnt_reset;
    logic             expired;
    logic [EXP_W-1:0] expire_cnt;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output clk_enable, start, stop, hold, periodic, period, count_q,
        input  cnt_enable, cnt_reset, expired, expire_cnt, busy, state
    );

    modport slave (
        input  clk_enable, start, stop, hold, periodic, period, count_q,
        output cnt_enable, cnt_reset, expired, expire_cnt, busy, state
    );
endinterface

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - interval timer controller steering an external up-counter
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   bus (slave)    clk_enable/start/stop/hold/periodic/period/count_q in,
//                  cnt_enable/cnt_reset/expired/expire_cnt/busy/state out
module interval_timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    interval_timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             periodic_q, periodic_d;
    logic             expired_q, expired_d;
    logic [EXP_W-1:0] expire_cnt_q, expire_cnt_d;

    logic run_tick;
    logic term;

    // A tick that would advance the counter in RUN; start/stop pre-empt it.
    assign run_tick = (state_q == RUN) & bus.clk_enable & ~bus.hold & ~bus.start & ~bus.stop;
    // period_q is never 0 while in RUN, so period_q-1 does not wrap here.
    assign term     = run_tick & (bus.count_q == (period_q - ONE));

    // One-shot holds the counter on its last value at term; IDLE clears it next cycle.
    assign bus.cnt_enable = run_tick & ~(term & ~periodic_q);
    assign bus.cnt_reset  = reset | (state_q == IDLE) | bus.start | bus.stop | (term & periodic_q);

    assign bus.expired    = expired_q;
    assign bus.expire_cnt = expire_cnt_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.state      = state_q;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        periodic_d   = periodic_q;
        expired_d    = 1'b0;
        expire_cnt_d = expire_cnt_q;

        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            if (bus.period != '0) begin
                state_d      = RUN;
                period_d     = bus.period;
                periodic_d   = bus.periodic;
                expire_cnt_d = '0;
            end else begin
                // Zero period: ignored from IDLE, an abort otherwise.
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.hold) begin
                        state_d = PAUSE;
                    end else if (term) begin
                        expired_d = 1'b1;
                        if (expire_cnt_q != EXP_MAX) begin
                            expire_cnt_d = expire_cnt_q + 1'b1;
                        end
                        if (!periodic_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                PAUSE: begin
                    if (!bus.hold) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            period_q     <= '0;
            periodic_q   <= 1'b0;
            expired_q    <= 1'b0;
            expire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            periodic_q   <= periodic_d;
            expired_q    <= expired_d;
            expire_cnt_q <= expire_cnt_d;
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - bench for interval_timer_ctrl with an external up-counter and reference model
module tb_interval_timer_ctrl;
    localparam int WIDTH = 8;
    localparam int EXP_W = 2;
    localparam int EMAX  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interval_timer_ctrl_if #(.WIDTH(WIDTH), .EXP_W(EXP_W)) bus ();

    interval_timer_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // External up-counter, reset has priority.
    logic [WIDTH-1:0] cnt;
    always_ff @(posedge clk) begin
        if (bus.cnt_reset) cnt <= '0;
        else if (bus.cnt_enable) cnt <= cnt + 1'b1;
    end
    assign bus.count_q = cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: 0=idle 1=run 2=pause; ticks = qualified ticks elapsed in the interval.
    int m_st, m_period, m_periodic, m_exp, m_ecnt, m_ticks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        bit final_tick, adv, term, e_en, e_rst;
        final_tick = (m_ticks + 1 == m_period);
        adv  = (m_st == 1) && bus.clk_enable && !bus.hold && !bus.start && !bus.stop;
        term = adv && final_tick;
        e_en  = adv && !(final_tick && m_periodic == 0);
        e_rst = reset || (m_st == 0) || bus.start || bus.stop || (term && m_periodic == 1);
        chk("state",      32'(bus.state),      32'(m_st));
        chk("busy",       32'(bus.busy),       32'(m_st != 0));
        chk("expired",    32'(bus.expired),    32'(m_exp));
        chk("expire_cnt", 32'(bus.expire_cnt), 32'(m_ecnt));
        chk("count_q",    32'(cnt),            32'(m_ticks));
        chk("cnt_enable", 32'(bus.cnt_enable), 32'(e_en));
        chk("cnt_reset",  32'(bus.cnt_reset),  32'(e_rst));
    endtask

    task automatic model_edge();
        if (reset) begin
            m_st = 0; m_period = 0; m_periodic = 0; m_exp = 0; m_ecnt = 0; m_ticks = 0;
        end else begin
            m_exp = 0;
            if (bus.stop) begin
                m_st = 0; m_ticks = 0;
            end else if (bus.start) begin
                m_ticks = 0;
                if (bus.period != 0) begin
                    m_st = 1; m_period = int'(bus.period); m_periodic = int'(bus.periodic); m_ecnt = 0;
                end else begin
                    m_st = 0;
                end
            end else if (m_st == 0) begin
                m_ticks = 0;
            end else if (m_st == 2) begin
                if (!bus.hold) m_st = 1;
            end else if (bus.hold) begin
                m_st = 2;
            end else if (bus.clk_enable) begin
                if (m_ticks + 1 == m_period) begin
                    m_exp = 1;
                    if (m_ecnt < EMAX) m_ecnt++;
                    if (m_periodic == 1) m_ticks = 0;
                    else m_st = 0;
                end else begin
                    m_ticks++;
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_until(input int v);
        int n = 0;
        while (int'(cnt) != v && n < 50) begin
            tick();
            n++;
        end
        chk("reach_count", 32'(cnt), 32'(v));
    endtask

    task automatic pulse_start(input int p, input bit per);
        bus.period = WIDTH'(p); bus.periodic = per; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.clk_enable = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
        bus.periodic = 1'b0; bus.period = '0;
        m_st = 0; m_period = 0; m_periodic = 0; m_exp = 0; m_ecnt = 0; m_ticks = 0;
        @(posedge clk); #1;
        tick(); tick();
        chk("rst_cnt_reset", 32'(bus.cnt_reset), 32'd1);
        chk("rst_cnt_enable", 32'(bus.cnt_enable), 32'd0);
        reset = 1'b0;
        bus.clk_enable = 1'b1;
        tick();

        // One-shot, period 4.
        pulse_start(4, 1'b0);
        repeat (4) tick();
        chk("oneshot_expired", 32'(bus.expired), 32'd1);
        chk("oneshot_state", 32'(bus.state), 32'd0);
        chk("oneshot_ecnt", 32'(bus.expire_cnt), 32'd1);
        repeat (3) tick();

        // Periodic, period 3, ticks every second cycle; period changes mid-run are ignored.
        pulse_start(3, 1'b1);
        bus.period = 8'd7; bus.periodic = 1'b0;
        for (int i = 0; i < 19; i++) begin
            bus.clk_enable = (i % 2 == 0);
            tick();
        end
        chk("periodic_ecnt", 32'(bus.expire_cnt), 32'd3);
        chk("periodic_busy", 32'(bus.busy), 32'd1);
        bus.clk_enable = 1'b1;
        pulse_stop();

        // Hold at count 2.
        pulse_start(5, 1'b0);
        run_until(2);
        bus.hold = 1'b1;
        repeat (4) tick();
        chk("hold_state", 32'(bus.state), 32'd2);
        chk("hold_count", 32'(cnt), 32'd2);
        bus.hold = 1'b0;
        repeat (6) tick();

        // Stop coincident with term.
        pulse_start(4, 1'b1);
        run_until(3);
        pulse_stop();
        chk("stop_term_expired", 32'(bus.expired), 32'd0);
        chk("stop_term_state", 32'(bus.state), 32'd0);

        // Start coincident with term.
        pulse_start(3, 1'b1);
        run_until(2);
        pulse_start(3, 1'b1);
        chk("start_term_expired", 32'(bus.expired), 32'd0);
        chk("start_term_count", 32'(cnt), 32'd0);
        chk("start_term_ecnt", 32'(bus.expire_cnt), 32'd0);
        pulse_stop();

        // Zero-period start from IDLE is ignored.
        pulse_start(0, 1'b1);
        chk("zero_period_state", 32'(bus.state), 32'd0);
        tick();

        // Period 1 periodic: expiry on every tick, counter saturates.
        pulse_start(1, 1'b1);
        repeat (5) tick();
        chk("sat_ecnt", 32'(bus.expire_cnt), 32'd3);
        chk("sat_expired", 32'(bus.expired), 32'd1);
        pulse_stop();

        // Reset mid-run at count 2.
        pulse_start(5, 1'b1);
        run_until(2);
        reset = 1'b1;
        tick();
        chk("rst_mid_state", 32'(bus.state), 32'd0);
        chk("rst_mid_expired", 32'(bus.expired), 32'd0);
        chk("rst_mid_ecnt", 32'(bus.expire_cnt), 32'd0);
        chk("rst_mid_cnt_reset", 32'(bus.cnt_reset), 32'd1);
        reset = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom % 150 == 0);
            bus.start      = ($urandom % 12 == 0);
            bus.stop       = ($urandom % 30 == 0);
            if ($urandom % 6 == 0) bus.hold = ~bus.hold;
            bus.clk_enable = ($urandom % 3 != 0);
            bus.period     = WIDTH'($urandom % 6);
            bus.periodic   = $urandom % 2;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
